// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 state encoding, frame length and parity helper.
package ps2_pkg;
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} ps2_state_t;
    localparam int FRAME_BITS = 11;
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-FF synchronizer for a raw PS/2 line plus falling-edge detect.
module ps2_line_sync (
    input  logic clk,
    input  logic clrn,
    input  logic raw,
    output logic sync,
    output logic fall
);
    logic [1:0] s_q, s_d;
    logic       prev_q, prev_d;
    always_comb begin
        s_d    = {s_q[0], raw};
        prev_d = s_q[1];
    end
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s_q    <= '0;
            prev_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            prev_q <= prev_d;
        end
    end
    assign sync = s_q[1];
    assign fall = prev_q & ~s_q[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter with clock-inhibit
// request, device-clocked shift-out, ACK check and inter-edge timeout.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       send,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int CMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    logic clk_s, clk_fall, data_s;

    ps2_line_sync u_clk_sync (
        .clk  (clk),
        .clrn (clrn),
        .raw  (ps2_clk_in),
        .sync (clk_s),
        .fall (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk  (clk),
        .clrn (clrn),
        .raw  (ps2_data_in),
        .sync (data_s),
        .fall ()
    );

    ps2_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [8:0]    shift_q, shift_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic          timed, tmo;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        timed     = state_q inside {REQ, SHIFT, ACK, WAIT_IDLE};
        tmo       = timed && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        if (timed) cnt_d = clk_fall ? '0 : cnt_q + 1'b1;
        case (state_q)
            IDLE: if (send) begin
                state_d  = INHIBIT;
                shift_d  = {odd_parity(tx_data), tx_data};
                cnt_d    = '0;
                busy_d   = 1'b1;
                clk_oe_d = 1'b1;
            end
            INHIBIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(INHIBIT_CYCLES - 2)) data_oe_d = 1'b1;
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    state_d  = REQ;
                    clk_oe_d = 1'b0;
                    cnt_d    = '0;
                end
            end
            REQ: if (clk_fall) begin
                data_oe_d = ~shift_q[0];
                shift_d   = shift_q >> 1;
                bitcnt_d  = 4'd1;
                state_d   = SHIFT;
            end
            SHIFT: if (clk_fall) begin
                if (bitcnt_q == 4'(FRAME_BITS - 2)) begin
                    data_oe_d = 1'b0;
                    state_d   = ACK;
                end else begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = shift_q >> 1;
                    bitcnt_d  = bitcnt_q + 4'd1;
                end
            end
            ACK: if (clk_fall) begin
                state_d = data_s ? IDLE : WAIT_IDLE;
                error_d = data_s;
                busy_d  = ~data_s;
            end
            WAIT_IDLE: if (clk_s && data_s) begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // timeout overrides whatever the state logic decided this cycle
        if (tmo) begin
            state_d   = IDLE;
            cnt_d     = '0;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            error_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: bench with a PS/2 device model on an open-drain bus.
module tb_ps2_host_tx;
    localparam int IC = 50;
    localparam int TC = 2000;
    localparam int H  = 15;

    logic       clk = 1'b0, clrn = 1'b0, send = 1'b0;
    logic [7:0] tx_data = '0;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, error;
    int         checks = 0, errors = 0;
    int         done_cnt = 0, err_cnt = 0, both_cnt = 0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(IC), .TIMEOUT_CYCLES(TC)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .tx_data     (tx_data),
        .send        (send),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        done_cnt = done_cnt + int'(done);
        err_cnt  = err_cnt + int'(error);
        both_cnt = both_cnt + int'(done && error);
    end

    initial begin
        #3ms;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // frame bit i as the device sees it: start, d0..d7, odd parity, stop
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2) == 0;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic start_send(input logic [7:0] b);
        int n;
        logic last_d;
        @(negedge clk);
        tx_data = b;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        check("busy_after_send", busy, 1);
        n = 0;
        last_d = 1'b0;
        while (ps2_clk_oe === 1'b1 && n < IC + 20) begin
            n++;
            last_d = ps2_data_oe;
            @(negedge clk);
        end
        check("inhibit_len", n, IC);
        check("start_in_last_inhibit", last_d, 1);
    endtask

    task automatic device_clocks(input bit ack, input int send_at, input int reset_at,
                                 output logic [10:0] got);
        got = '0;
        got[0] = ps2_data_in;
        repeat (H) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            if (k == send_at) begin
                tx_data = 8'h55;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
                tx_data = 8'h00;
                repeat (H - 1) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            if (k == reset_at) begin
                #1 clrn = 1'b0;
                #1;
                check("rst_clk_oe", ps2_clk_oe, 0);
                check("rst_data_oe", ps2_data_oe, 0);
                check("rst_busy", busy, 0);
                dev_clk_low = 1'b0;
                dev_data_low = 1'b0;
                @(negedge clk);
                clrn = 1'b1;
                return;
            end
            dev_clk_low = 1'b0;
            if (k <= 10) got[k] = ps2_data_in;
            if (k == 10 && ack) dev_data_low = 1'b1;
            if (k == 11) dev_data_low = 1'b0;
            repeat (H) @(negedge clk);
        end
    endtask

    task automatic do_xfer(input logic [7:0] b, input bit ack, input int send_at,
                           input logic [7:0] exp_b);
        int d0, e0;
        logic [10:0] got;
        d0 = done_cnt;
        e0 = err_cnt;
        start_send(b);
        check("req_start_bit", ps2_data_oe, 1);
        repeat (20) @(negedge clk);
        device_clocks(ack, send_at, 0, got);
        check("frame", got, ref_frame(exp_b));
        repeat (10) @(negedge clk);
        check("done_pulses", done_cnt - d0, ack ? 1 : 0);
        check("error_pulses", err_cnt - e0, ack ? 0 : 1);
        check("busy_end", busy, 0);
        check("clk_oe_end", ps2_clk_oe, 0);
        check("data_oe_end", ps2_data_oe, 0);
    endtask

    initial begin
        int n, e0;
        logic [10:0] got;
        repeat (3) @(negedge clk);
        check("reset_clk_oe", ps2_clk_oe, 0);
        check("reset_data_oe", ps2_data_oe, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        do_xfer(8'hED, 1'b1, 0, 8'hED);
        do_xfer(8'h02, 1'b1, 0, 8'h02);
        do_xfer(8'hA7, 1'b0, 0, 8'hA7);
        do_xfer(8'hED, 1'b1, 4, 8'hED);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            do_xfer(r, 1'b1, 0, r);
        end

        e0 = err_cnt;
        start_send(8'hF4);
        n = 0;
        while (error !== 1'b1 && n < TC + 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TC);
        check("timeout_clk_oe", ps2_clk_oe, 0);
        check("timeout_data_oe", ps2_data_oe, 0);
        check("timeout_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("timeout_error_pulses", err_cnt - e0, 1);

        e0 = done_cnt + err_cnt;
        start_send(8'hED);
        repeat (20) @(negedge clk);
        device_clocks(1'b1, 0, 5, got);
        repeat (5) @(negedge clk);
        check("rst_no_pulse", done_cnt + err_cnt - e0, 0);
        do_xfer(8'hF4, 1'b1, 0, 8'hF4);

        check("done_error_exclusive", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
